regfile_operand_stage: RTL and testbench

// Integer register file plus ID/EX operand latch. Sits directly upstream of the

---
 rtl/regfile_operand_stage.sv | 104 ++++++++++
 tb/tb_regfile_operand_stage.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_operand_stage.sv
// Integer register file with write-first bypass feeding a registered ID/EX operand
// latch (op_a / op_b / op_rs2) for the downstream ripple ALU; supports stall and flush.
module regfile_operand_stage #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [AW-1:0]   rs1_addr,
  input  logic [AW-1:0]   rs2_addr,
  input  logic [XLEN-1:0] imm,
  input  logic            alu_src_b,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [AW-1:0]   wb_addr,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [XLEN-1:0] op_rs2,
  output logic            out_valid
);

  logic [XLEN-1:0] r_regs [NREG];
  logic [XLEN-1:0] r_op_a;
  logic [XLEN-1:0] r_op_b;
  logic [XLEN-1:0] r_op_rs2;
  logic            r_out_valid;

  logic            w_wb_live;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic [XLEN-1:0] w_op_b_next;

  assign w_wb_live = wb_we && (wb_addr != '0) && (int'(wb_addr) < NREG);

  // NOTE: the register array sits under the async reset because the whole file
  // must read as zero straight after reset; this costs a reset net per bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wb_live) begin
      r_regs[wb_addr] <= wb_data;
    end
  end

  // Write-first read: a same-cycle writeback to the addressed register wins.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    w_rs1_val = '0;
    if (rs1_addr == '0 || int'(rs1_addr) >= NREG) begin
      w_rs1_val = '0;
    end else if (wb_we && wb_addr == rs1_addr) begin
      w_rs1_val = wb_data;
    end else begin
      w_rs1_val = r_regs[rs1_addr];
    end
  end

  always_comb begin
    w_rs2_val = '0;
    if (rs2_addr == '0 || int'(rs2_addr) >= NREG) begin
      w_rs2_val = '0;
    end else if (wb_we && wb_addr == rs2_addr) begin
      w_rs2_val = wb_data;
    end else begin
      w_rs2_val = r_regs[rs2_addr];
    end
  end

  assign w_op_b_next = alu_src_b ? imm : w_rs2_val;

  // Flush beats stall; data fields are captured regardless of in_valid.
  // NOTE: sequential state uses non-blocking assignments so all flops sample
  // the pre-edge values of each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_rs2    <= '0;
      r_out_valid <= 1'b0;
    end else if (flush) begin
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_op_rs2    <= '0;
      r_out_valid <= 1'b0;
    end else if (!stall) begin
      r_op_a      <= w_rs1_val;
      r_op_b      <= w_op_b_next;
      r_op_rs2    <= w_rs2_val;
      r_out_valid <= in_valid;
    end
  end

  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign op_rs2    = r_op_rs2;
  assign out_valid = r_out_valid;

endmodule

// File: tb/tb_regfile_operand_stage.sv
// Self-checking bench for regfile_operand_stage: table-driven vectors whose expected
// operands go through a scoreboard queue, plus hand sequences for async reset.
module tb_regfile_operand_stage;

  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [AW-1:0]   rs1_addr, rs2_addr, wb_addr;
  logic [XLEN-1:0] imm, wb_data;
  logic            alu_src_b, in_valid, stall, flush, wb_we;
  logic [XLEN-1:0] op_a, op_b, op_rs2;
  logic            out_valid;

  typedef struct packed {
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] rs2;
    logic            valid;
  } exp_t;

  typedef struct packed {
    logic [AW-1:0]   rs1;
    logic [AW-1:0]   rs2;
    logic [XLEN-1:0] imm;
    logic            src_b;
    logic            in_valid;
    logic            stall;
    logic            flush;
    logic            wb_we;
    logic [AW-1:0]   wb_addr;
    logic [XLEN-1:0] wb_data;
    exp_t            exp;
  } vec_t;

  int checks = 0;
  int errors = 0;
  exp_t sb_q[$];
  vec_t vecs[$];

  regfile_operand_stage #(.XLEN(XLEN), .NREG(32), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .imm(imm),
    .alu_src_b(alu_src_b), .in_valid(in_valid), .stall(stall), .flush(flush),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .op_a(op_a), .op_b(op_b), .op_rs2(op_rs2), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [XLEN-1:0] act,
                       input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [AW-1:0] rs1, input logic [AW-1:0] rs2,
                              input logic [XLEN-1:0] im, input logic sb,
                              input logic iv, input logic st, input logic fl,
                              input logic we, input logic [AW-1:0] wa,
                              input logic [XLEN-1:0] wd,
                              input logic [XLEN-1:0] ea, input logic [XLEN-1:0] eb,
                              input logic [XLEN-1:0] er, input logic ev);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.imm = im; v.src_b = sb; v.in_valid = iv;
    v.stall = st; v.flush = fl; v.wb_we = we; v.wb_addr = wa; v.wb_data = wd;
    v.exp.a = ea; v.exp.b = eb; v.exp.rs2 = er; v.exp.valid = ev;
    return v;
  endfunction

  task automatic idle_inputs();
    rs1_addr = '0; rs2_addr = '0; imm = '0; alu_src_b = 1'b0; in_valid = 1'b0;
    stall = 1'b0; flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".op_a"},      op_a,             e.a);
    check({tag, ".op_b"},      op_b,             e.b);
    check({tag, ".op_rs2"},    op_rs2,           e.rs2);
    check({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, e.valid});
  endtask

  // Drive one vector at the falling edge, push its expectation, then pop and
  // compare just after the capturing rising edge.
  task automatic apply(input int idx, input vec_t v);
    exp_t e;
    @(negedge clk);
    rs1_addr = v.rs1; rs2_addr = v.rs2; imm = v.imm; alu_src_b = v.src_b;
    in_valid = v.in_valid; stall = v.stall; flush = v.flush;
    wb_we = v.wb_we; wb_addr = v.wb_addr; wb_data = v.wb_data;
    sb_q.push_back(v.exp);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_empty vec=%0d actual=0 required=1", idx);
    end else begin
      e = sb_q.pop_front();
      check_outputs($sformatf("vec%0d", idx), e);
    end
  endtask

  initial begin
    exp_t zero_e;
    zero_e = '0;
    idle_inputs();

    // Reset at time zero: outputs cleared without any clock edge.
    rst_n = 1'b0;
    #2;
    check_outputs("reset0", zero_e);
    @(negedge clk);
    rst_n = 1'b1;

    //          rs1 rs2 imm           sb iv st fl we wa wd             exp_a          exp_b          exp_rs2        ev
    vecs.push_back(mk(0, 0, 32'h0,          0, 0, 0, 0, 1, 5, 32'hDEAD_BEEF, 32'h0,         32'h0,         32'h0,         0));
    vecs.push_back(mk(5, 5, 32'h0,          0, 1, 0, 0, 0, 0, 32'h0,         32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1));
    vecs.push_back(mk(0, 0, 32'h0,          0, 1, 0, 0, 1, 7, 32'h1111_1111, 32'h0,         32'h0,         32'h0,         1));
    vecs.push_back(mk(7, 0, 32'h0,          0, 1, 0, 0, 1, 7, 32'h0000_1234, 32'h0000_1234, 32'h0,         32'h0,         1));
    vecs.push_back(mk(7, 0, 32'h0,          0, 1, 0, 0, 0, 0, 32'h0,         32'h0000_1234, 32'h0,         32'h0,         1));
    vecs.push_back(mk(0, 0, 32'h0,          0, 1, 0, 0, 1, 0, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0,         1));
    vecs.push_back(mk(0, 0, 32'h0,          0, 1, 0, 0, 1, 0, 32'hFFFF_FFFF, 32'h0,         32'h0,         32'h0,         1));
    vecs.push_back(mk(5, 5, 32'hFFFF_FFF0,  1, 1, 0, 0, 0, 0, 32'h0,         32'hDEAD_BEEF, 32'hFFFF_FFF0, 32'hDEAD_BEEF, 1));
    vecs.push_back(mk(7, 5, 32'h0,          0, 0, 0, 0, 0, 0, 32'h0,         32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(5, 9, 32'h0,          0, 1, 0, 0, 1, 9, 32'hCAFE_0009, 32'hDEAD_BEEF, 32'hCAFE_0009, 32'hCAFE_0009, 1));
    vecs.push_back(mk(5, 9, 32'h0,          0, 1, 0, 0, 0, 5, 32'h0,         32'hDEAD_BEEF, 32'hCAFE_0009, 32'hCAFE_0009, 1));
    // Stall/flush: capture A, hold through three stalled cycles while inputs
    // and x7 change, then release and finally stall+flush together.
    vecs.push_back(mk(7, 5, 32'h0,          0, 1, 0, 0, 0, 0, 32'h0,         32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1));
    vecs.push_back(mk(9, 9, 32'h5555_5555,  1, 0, 1, 0, 1, 7, 32'h7777_7777, 32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1));
    vecs.push_back(mk(9, 9, 32'h5555_5555,  0, 0, 1, 0, 0, 0, 32'h0,         32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1));
    vecs.push_back(mk(7, 9, 32'h0,          1, 0, 1, 0, 0, 0, 32'h0,         32'h0000_1234, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1));
    vecs.push_back(mk(7, 5, 32'h0,          0, 1, 0, 0, 0, 0, 32'h0,         32'h7777_7777, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1));
    vecs.push_back(mk(5, 5, 32'h0,          0, 1, 1, 1, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         0));
    vecs.push_back(mk(9, 5, 32'h0,          0, 1, 0, 0, 0, 0, 32'h0,         32'hCAFE_0009, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1));
    vecs.push_back(mk(9, 5, 32'h0,          0, 1, 0, 1, 0, 0, 32'h0,         32'h0,         32'h0,         32'h0,         0));
    vecs.push_back(mk(5, 9, 32'hAAAA_5555,  1, 1, 0, 0, 0, 0, 32'h0,         32'hDEAD_BEEF, 32'hAAAA_5555, 32'hCAFE_0009, 1));

    foreach (vecs[i]) apply(i, vecs[i]);

    // Async reset mid-cycle while a stall and a writeback are in progress.
    @(negedge clk);
    stall = 1'b1; wb_we = 1'b1; wb_addr = 5'd3; wb_data = 32'h3333_3333;
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", zero_e);
    @(posedge clk);
    #1;
    check_outputs("reset_held", zero_e);
    @(negedge clk);
    idle_inputs();
    rst_n = 1'b1;

    // Every register reads zero after reset (x5, x7, x9 held data before).
    for (int r = 1; r < 32; r++) begin
      @(negedge clk);
      rs1_addr = AW'(r); rs2_addr = AW'(r); alu_src_b = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      check($sformatf("post_reset_x%0d.op_a", r), op_a, 32'h0);
      check($sformatf("post_reset_x%0d.op_rs2", r), op_rs2, 32'h0);
    end

    if (sb_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_leftover actual=%0d required=0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
